// File: rtl/nios_system_ocimem_pkg.sv
// Shared types and jdo field layout for the OCI RAM arbiter.
package nios_system_ocimem_pkg;
  typedef enum logic [2:0] {IDLE, GNT_J, GNT_C, CAP_J, CAP_C} state_e;
  typedef enum logic {CMD_RD, CMD_WR} cmd_e;
  typedef enum logic {GRANT_CPU, GRANT_JTAG} grant_e;

  localparam int JDO_W       = 38;
  localparam int JDO_ADDR_HI = 25;
  localparam int JDO_ADDR_LO = 18;
  localparam int JDO_RD_BIT  = 34;
  localparam int JDO_WD_HI   = 34;
  localparam int JDO_WD_LO   = 3;
endpackage

// File: rtl/nios_system_ocimem_jtag_cmdq.sv
// One-deep JTAG command slot: pulse priority, overrun flag and the monitor address register.
module nios_system_ocimem_jtag_cmdq
  import nios_system_ocimem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int JTAG_AUTOINC = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              in_service,
  input  logic              done,
  output logic              pending,
  output cmd_e              pend_type,
  output logic [DATA_W-1:0] pend_data,
  output logic [ADDR_W-1:0] mon_addr,
  output logic              overrun
);
  logic              pend_q, pend_d;
  cmd_e              type_q, type_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovr_q, ovr_d;
  logic              busy;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_WD_HI+1], jdo[JDO_WD_LO-1:0]};
  assign busy       = pend_q | in_service;

  always_comb begin
    pend_d = pend_q;
    type_d = type_q;
    data_d = data_q;
    addr_d = addr_q;
    ovr_d  = ovr_q;
    if (done) begin
      pend_d = 1'b0;
      if (JTAG_AUTOINC != 0) addr_d = addr_q + ADDR_W'(1);
    end
    // Only the highest-priority pulse counts; the others are ignored outright.
    if (take_action_ocimem_b) begin
      if (busy) ovr_d = 1'b1;
      else begin
        pend_d = 1'b1;
        type_d = CMD_WR;
        data_d = jdo[JDO_WD_HI:JDO_WD_LO];
      end
    end else if (take_action_ocimem_a) begin
      addr_d = ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
      if (busy) ovr_d = 1'b1;
      else if (jdo[JDO_RD_BIT]) begin
        pend_d = 1'b1;
        type_d = CMD_RD;
      end
    end else if (take_no_action_ocimem_a) begin
      if (busy) ovr_d = 1'b1;
      else begin
        pend_d = 1'b1;
        type_d = CMD_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      type_q <= CMD_RD;
      data_q <= '0;
      addr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      type_q <= type_d;
      data_q <= data_d;
      addr_q <= addr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pending   = pend_q;
  assign pend_type = type_q;
  assign pend_data = data_q;
  assign mon_addr  = addr_q;
  assign overrun   = ovr_q;
endmodule

// File: rtl/nios_system_nios2_qsys_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between the JTAG debug path and the CPU debug slave.
module nios_system_nios2_qsys_ocimem_arbiter
  import nios_system_ocimem_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int JTAG_AUTOINC = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic              cpu_debugaccess,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  output logic              jtag_overrun
);
  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mond_q, mond_d;
  logic              pending, in_service, j_done, cpu_req;
  cmd_e              pend_type;
  logic [DATA_W-1:0] pend_data;
  logic              ram_wr_c, cpu_wait_c;

  assign cpu_req    = cpu_read | cpu_write;
  assign in_service = (state_q == GNT_J) || (state_q == CAP_J);

  nios_system_ocimem_jtag_cmdq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .JTAG_AUTOINC(JTAG_AUTOINC)
  ) u_cmdq (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .in_service             (in_service),
    .done                   (j_done),
    .pending                (pending),
    .pend_type              (pend_type),
    .pend_data              (pend_data),
    .mon_addr               (MonAReg),
    .overrun                (jtag_overrun)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    rdata_d      = rdata_q;
    mond_d       = mond_q;
    j_done       = 1'b0;
    ram_addr     = '0;
    ram_wr_c     = 1'b0;
    ram_wdata    = '0;
    cpu_wait_c   = 1'b1;
    cpu_readdata = rdata_q;
    unique case (state_q)
      IDLE: begin
        // With both requesting, the side not served last wins.
        if (pending && (!cpu_req || last_q == GRANT_CPU)) begin
          state_d = GNT_J;
          last_d  = GRANT_JTAG;
        end else if (cpu_req) begin
          state_d = GNT_C;
          last_d  = GRANT_CPU;
        end
      end
      GNT_J: begin
        ram_addr = MonAReg;
        if (pend_type == CMD_WR) begin
          ram_wr_c  = 1'b1;
          ram_wdata = pend_data;
          j_done    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = CAP_J;
        end
      end
      CAP_J: begin
        mond_d  = ram_rdata;
        j_done  = 1'b1;
        state_d = IDLE;
      end
      GNT_C: begin
        ram_addr = cpu_address;
        if (cpu_write) begin
          ram_wr_c   = cpu_debugaccess;
          ram_wdata  = cpu_writedata;
          cpu_wait_c = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = CAP_C;
        end
      end
      CAP_C: begin
        rdata_d      = ram_rdata;
        cpu_readdata = ram_rdata;
        cpu_wait_c   = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must suppress a write or an ack already decoded from the current state.
  assign ram_wr          = ram_wr_c & reset_n;
  assign cpu_waitrequest = cpu_wait_c | ~reset_n;
  assign jtag_busy       = pending | in_service;
  assign MonDReg         = mond_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= GRANT_CPU;
      rdata_q <= '0;
      mond_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      mond_q  <= mond_d;
    end
  end
endmodule

// File: tb/tb_nios_system_nios2_qsys_ocimem_arbiter.sv
// Directed bench: cycle-vector table for the basic JTAG/CPU flows, hand sequences for corner cases.
module tb_nios_system_nios2_qsys_ocimem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write, cpu_debugaccess;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        jtag_busy, jtag_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_system_nios2_qsys_ocimem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_debugaccess(cpu_debugaccess),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .MonAReg(MonAReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {24'hC0DE00, a};
  endfunction

  // OCI RAM model: 1-cycle read latency, preloaded with pat() on the first edge.
  logic [31:0] mem [256];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      init_done <= 1'b1;
    end else if (ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [37:0] ja(input logic [7:0] a, input logic rd);
    logic [37:0] j;
    j = '0;
    j[25:18] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] jw(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  typedef struct {
    logic ta_a, ta_b, na_a;
    logic [37:0] jdo;
    logic crd, cwr, cdbg;
    logic [7:0] caddr;
    logic [31:0] cwd;
    logic e_wr, e_wait, ck_addr;
    logic [7:0] e_addr;
    logic [31:0] e_wdata;
    logic ck_rd;
    logic [31:0] e_rdata;
    logic [7:0] e_mona;
    logic [31:0] e_mond;
    logic e_busy, e_ovr;
  } vec_t;

  function automatic vec_t v(
    input logic ta_a, ta_b, na_a, input logic [37:0] j,
    input logic crd, cwr, cdbg, input logic [7:0] caddr, input logic [31:0] cwd,
    input logic e_wr, e_wait, ck_addr, input logic [7:0] e_addr, input logic [31:0] e_wdata,
    input logic ck_rd, input logic [31:0] e_rdata, input logic [7:0] e_mona,
    input logic [31:0] e_mond, input logic e_busy, e_ovr);
    vec_t r;
    r.ta_a = ta_a; r.ta_b = ta_b; r.na_a = na_a; r.jdo = j;
    r.crd = crd; r.cwr = cwr; r.cdbg = cdbg; r.caddr = caddr; r.cwd = cwd;
    r.e_wr = e_wr; r.e_wait = e_wait; r.ck_addr = ck_addr; r.e_addr = e_addr;
    r.e_wdata = e_wdata; r.ck_rd = ck_rd; r.e_rdata = e_rdata; r.e_mona = e_mona;
    r.e_mond = e_mond; r.e_busy = e_busy; r.e_ovr = e_ovr;
    return r;
  endfunction

  task automatic clr_in();
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    jdo = '0; cpu_read = 0; cpu_write = 0; cpu_debugaccess = 0;
    cpu_address = '0; cpu_writedata = '0;
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!cpu_waitrequest) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  initial begin
    vec_t tbl[$];
    vec_t r;
    logic ok, prev;
    int gap, jdone, nwr;
    logic [31:0] x;

    clr_in();
    reset_n = 0;
    repeat (2) @(negedge clk);
    chk1("rst_wait", cpu_waitrequest, 1'b1);
    chk1("rst_ram_wr", ram_wr, 1'b0);
    chk32("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk32("rst_ram_wdata", ram_wdata, 32'h0);
    chk32("rst_rdata", cpu_readdata, 32'h0);
    chk32("rst_mond", MonDReg, 32'h0);
    chk32("rst_mona", 32'(MonAReg), 32'h0);
    chk1("rst_busy", jtag_busy, 1'b0);
    chk1("rst_ovr", jtag_overrun, 1'b0);
    reset_n = 1;
    @(negedge clk);

    //              ta_a tb na jdo           rd wr dbg addr   wdata        | wr wt ck addr  wdata  ckrd rdata mona   mond busy ovr
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h00, 32'h0, 0, 0));
    tbl.push_back(v(1, 0, 0, ja(8'h10, 0), 0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h00, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 0, jw(DB),       0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h10, 32'h0, 0, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h10, 32'h0, 1, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         1, 1, 1, 8'h10, DB,    0, 32'h0, 8'h10, 32'h0, 1, 0));
    tbl.push_back(v(1, 0, 0, ja(8'h10, 1), 0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h11, 32'h0, 0, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h10, 32'h0, 1, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         0, 1, 1, 8'h10, 32'h0, 0, 32'h0, 8'h10, 32'h0, 1, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h10, 32'h0, 1, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 1, 1, 8'h20, A5,            0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 1, 1, 8'h20, A5,            1, 0, 1, 8'h20, A5,    0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           1, 0, 0, 8'h20, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           1, 0, 0, 8'h20, 32'h0,         0, 1, 1, 8'h20, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           1, 0, 0, 8'h20, 32'h0,         0, 0, 0, 8'h00, 32'h0, 1, A5,    8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 1, 0, 8'h20, 32'h12345678,  0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 1, 0, 8'h20, 32'h12345678,  0, 0, 1, 8'h20, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           1, 0, 0, 8'h20, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           1, 0, 0, 8'h20, 32'h0,         0, 1, 1, 8'h20, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           1, 0, 0, 8'h20, 32'h0,         0, 0, 0, 8'h00, 32'h0, 1, A5,    8'h11, DB,    0, 0));
    tbl.push_back(v(0, 0, 0, '0,           0, 0, 0, 8'h00, 32'h0,         0, 1, 0, 8'h00, 32'h0, 0, 32'h0, 8'h11, DB,    0, 0));

    foreach (tbl[k]) begin
      r = tbl[k];
      take_action_ocimem_a = r.ta_a; take_action_ocimem_b = r.ta_b;
      take_no_action_ocimem_a = r.na_a; jdo = r.jdo;
      cpu_read = r.crd; cpu_write = r.cwr; cpu_debugaccess = r.cdbg;
      cpu_address = r.caddr; cpu_writedata = r.cwd;
      #1;
      chk1($sformatf("row%0d_wait", k), cpu_waitrequest, r.e_wait);
      chk1($sformatf("row%0d_ram_wr", k), ram_wr, r.e_wr);
      chk32($sformatf("row%0d_mona", k), 32'(MonAReg), 32'(r.e_mona));
      chk32($sformatf("row%0d_mond", k), MonDReg, r.e_mond);
      chk1($sformatf("row%0d_busy", k), jtag_busy, r.e_busy);
      chk1($sformatf("row%0d_ovr", k), jtag_overrun, r.e_ovr);
      if (r.ck_addr) chk32($sformatf("row%0d_ram_addr", k), 32'(ram_addr), 32'(r.e_addr));
      if (r.e_wr) chk32($sformatf("row%0d_ram_wdata", k), ram_wdata, r.e_wdata);
      if (r.ck_rd) chk32($sformatf("row%0d_rdata", k), cpu_readdata, r.e_rdata);
      @(negedge clk);
    end
    clr_in();
    chk32("mem_10", mem[8'h10], DB);
    chk32("mem_20_nodbg", mem[8'h20], A5);

    // Overrun: second write pulse lands while the first is still pending.
    take_action_ocimem_b = 1; jdo = jw(32'h11112222);
    @(negedge clk);
    jdo = jw(32'h33334444);
    @(negedge clk);
    clr_in();
    chk1("ovr_set", jtag_overrun, 1'b1);
    repeat (4) @(negedge clk);
    chk1("ovr_sticky", jtag_overrun, 1'b1);
    chk1("ovr_idle", jtag_busy, 1'b0);
    chk32("ovr_mona", 32'(MonAReg), 32'h12);
    chk32("ovr_mem11", mem[8'h11], 32'h11112222);

    // Simultaneous b and a: only the write is served, no overrun.
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    chk1("ovr_cleared", jtag_overrun, 1'b0);
    x = 32'h9ABCDEF0;
    take_action_ocimem_a = 1; take_action_ocimem_b = 1; jdo = jw(x);
    @(negedge clk);
    clr_in();
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      if (ram_wr && ram_wdata == x) nwr++;
      @(negedge clk);
    end
    chk32("sim_one_write", 32'(nwr), 32'd1);
    chk1("sim_no_ovr", jtag_overrun, 1'b0);
    chk1("sim_idle", jtag_busy, 1'b0);
    chk32("sim_no_read", MonDReg, 32'h0);

    // Address wrap.
    take_action_ocimem_a = 1; jdo = ja(8'hFF, 0);
    @(negedge clk);
    clr_in();
    chk32("wrap_load", 32'(MonAReg), 32'hFF);
    take_action_ocimem_b = 1; jdo = jw(32'h0BADF00D);
    @(negedge clk);
    clr_in();
    repeat (4) @(negedge clk);
    chk32("wrap_mona", 32'(MonAReg), 32'h00);
    chk32("wrap_memff", mem[8'hFF], 32'h0BADF00D);

    // Contention: CPU read held continuously, JTAG read pulsed during each CPU ack.
    take_action_ocimem_a = 1; jdo = ja(8'h80, 0);
    @(negedge clk);
    clr_in();
    @(negedge clk);
    cpu_read = 1; cpu_address = 8'h20;
    wait_ack(ok);
    chk1("cont_first_ack", ok, 1'b1);
    for (int it = 0; it < 100; it++) begin
      take_no_action_ocimem_a = 1;
      @(negedge clk);
      take_no_action_ocimem_a = 0;
      gap = 0; jdone = 0; prev = 1'b1;
      while (cpu_waitrequest && gap < 20) begin
        if (prev && !jtag_busy) jdone++;
        prev = jtag_busy;
        @(negedge clk);
        gap++;
      end
      chk32($sformatf("cont%0d_gap", it), 32'(gap), 32'd5);
      chk32($sformatf("cont%0d_jdone", it), 32'(jdone), 32'd1);
      chk32($sformatf("cont%0d_mond", it), MonDReg, pat(8'(8'h80 + it)));
      chk32($sformatf("cont%0d_rdata", it), cpu_readdata, A5);
    end
    clr_in();
    @(negedge clk);
    chk1("cont_no_ovr", jtag_overrun, 1'b0);

    // Reset arriving in a JTAG write grant cycle must block the write.
    take_action_ocimem_b = 1; jdo = jw(32'h55AA55AA);
    @(negedge clk);
    clr_in();
    @(negedge clk);
    reset_n = 0;
    #1;
    chk1("rstw_no_wr", ram_wr, 1'b0);
    @(negedge clk);
    reset_n = 1;
    chk1("rstw_busy", jtag_busy, 1'b0);
    repeat (2) @(negedge clk);
    chk32("rstw_mem", mem[8'hE4], pat(8'hE4));

    // Reset during CAP_C.
    cpu_read = 1; cpu_address = 8'h20;
    repeat (2) @(negedge clk);
    chk1("rstr_in_cap", cpu_waitrequest, 1'b0);
    reset_n = 0;
    cpu_read = 0;
    @(negedge clk);
    reset_n = 1;
    chk1("rstr_wait", cpu_waitrequest, 1'b1);
    chk32("rstr_rdata", cpu_readdata, 32'h0);
    chk1("rstr_ram_wr", ram_wr, 1'b0);
    chk32("rstr_ram_addr", 32'(ram_addr), 32'h0);
    chk32("rstr_mond", MonDReg, 32'h0);
    chk32("rstr_mona", 32'(MonAReg), 32'h0);
    chk1("rstr_busy", jtag_busy, 1'b0);
    @(negedge clk);
    chk1("rstr_still_wait", cpu_waitrequest, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
